blink_rate_decoder: RTL and testbench

Measures the toggle rate of an incoming square wave (e.g. an LED drive line from a blinker on another board) and classifies it as one of the four standard blink rates: 100 Hz, 50 Hz, 10 Hz or 1 Hz. It is the receive side of the switch-selected LED blinker, and it reports the same 2-bit rate code that the blinker's switch pair selects. The block sits between a board input pin and status or readback logic. It has a synchronizer, a half-period counter, a tolerance classifier and a lock/timeout stage.

---
 rtl/blink_rate_decoder.sv | 179 +++++++++++++++++
 tb/tb_blink_rate_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/blink_rate_decoder.sv
// rtl/blink_rate_decoder.sv - measures an incoming square wave's half-period and
// locks onto one of four blink rates (100/50/10/1 Hz).
module blink_rate_decoder #(
   parameter int unsigned c_CNT_100HZ  = 125000,
   parameter int unsigned c_CNT_50HZ   = 250000,
   parameter int unsigned c_CNT_10HZ   = 1250000,
   parameter int unsigned c_CNT_1HZ    = 12500000,
   parameter int unsigned c_TOL_SHIFT  = 3,
   parameter int unsigned c_LOCK_COUNT = 2,
   parameter int unsigned c_TIMEOUT    = 25000000
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_signal,
   output logic [1:0]  o_rate,
   output logic        o_valid,
   output logic        o_update,
   output logic [31:0] o_half_period
);

   localparam int c_LW = $clog2(c_LOCK_COUNT + 1);
   localparam logic [c_LW-1:0] c_LC  = c_LW'(c_LOCK_COUNT);
   localparam logic [c_LW-1:0] c_ONE = c_LW'(1);
   localparam logic [31:0] c_TO = 32'(c_TIMEOUT);

   localparam logic [31:0] c_LO_100 = 32'(c_CNT_100HZ - (c_CNT_100HZ >> c_TOL_SHIFT));
   localparam logic [31:0] c_HI_100 = 32'(c_CNT_100HZ + (c_CNT_100HZ >> c_TOL_SHIFT));
   localparam logic [31:0] c_LO_50  = 32'(c_CNT_50HZ  - (c_CNT_50HZ  >> c_TOL_SHIFT));
   localparam logic [31:0] c_HI_50  = 32'(c_CNT_50HZ  + (c_CNT_50HZ  >> c_TOL_SHIFT));
   localparam logic [31:0] c_LO_10  = 32'(c_CNT_10HZ  - (c_CNT_10HZ  >> c_TOL_SHIFT));
   localparam logic [31:0] c_HI_10  = 32'(c_CNT_10HZ  + (c_CNT_10HZ  >> c_TOL_SHIFT));
   localparam logic [31:0] c_LO_1   = 32'(c_CNT_1HZ   - (c_CNT_1HZ   >> c_TOL_SHIFT));
   localparam logic [31:0] c_HI_1   = 32'(c_CNT_1HZ   + (c_CNT_1HZ   >> c_TOL_SHIFT));

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

   logic            sync1, sync2, sync3;
   logic            sig_edge;
   logic [31:0]     r_cnt;
   logic [31:0]     meas;
   logic            r_armed;
   logic            timeout;
   logic            hit;
   logic [1:0]      cls;
   logic            meas_pulse;
   logic            meas_match;
   logic [1:0]      meas_class;

   state_t          state, state_n;
   logic [1:0]      cand, cand_n;
   logic [c_LW-1:0] lock_cnt, lock_n;
   logic [c_LW-1:0] lock_inc, lock_nxt;
   logic            lock_entry;
   logic [1:0]      rate_n;
   logic            valid_n, update_n;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= i_signal;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign sig_edge = sync2 ^ sync3;
   assign meas     = r_cnt + 32'd1;
   // An edge landing on the saturated count wins over the timeout.
   assign timeout  = (r_cnt == c_TO) && !sig_edge;

   always_comb begin
      hit = 1'b1;
      cls = 2'd0;
      if (meas >= c_LO_100 && meas <= c_HI_100)
         cls = 2'd0;
      else if (meas >= c_LO_50 && meas <= c_HI_50)
         cls = 2'd1;
      else if (meas >= c_LO_10 && meas <= c_HI_10)
         cls = 2'd2;
      else if (meas >= c_LO_1 && meas <= c_HI_1)
         cls = 2'd3;
      else
         hit = 1'b0;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt         <= '0;
         r_armed       <= 1'b0;
         o_half_period <= '0;
         meas_pulse    <= 1'b0;
         meas_match    <= 1'b0;
         meas_class    <= 2'd0;
      end else begin
         meas_pulse <= 1'b0;
         if (sig_edge) begin
            r_cnt   <= '0;
            r_armed <= 1'b1;
            if (r_armed) begin
               o_half_period <= meas;
               meas_pulse    <= 1'b1;
               meas_match    <= hit;
               meas_class    <= cls;
            end
         end else if (r_cnt != c_TO) begin
            r_cnt <= r_cnt + 32'd1;
         end else begin
            r_armed <= 1'b0;
         end
      end
   end

   // Lock count this measurement would produce if it matched a bin.
   assign lock_inc   = (lock_cnt == c_LC) ? lock_cnt : lock_cnt + 1'b1;
   assign lock_nxt   = (meas_class == cand) ? lock_inc : c_ONE;
   assign lock_entry = !timeout && meas_pulse && meas_match &&
                       (state == UNLOCKED || meas_class != cand) &&
                       (lock_nxt == c_LC);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= UNLOCKED;
         cand     <= 2'd0;
         lock_cnt <= '0;
         o_rate   <= 2'd0;
         o_valid  <= 1'b0;
         o_update <= 1'b0;
      end else begin
         state    <= state_n;
         cand     <= cand_n;
         lock_cnt <= lock_n;
         o_rate   <= rate_n;
         o_valid  <= valid_n;
         o_update <= update_n;
      end
   end

   always_comb begin
      state_n = state;
      if (timeout)
         state_n = UNLOCKED;
      else if (meas_pulse && (!meas_match || meas_class != cand))
         state_n = UNLOCKED;
      if (lock_entry)
         state_n = LOCKED;
   end

   always_comb begin
      cand_n   = cand;
      lock_n   = lock_cnt;
      rate_n   = o_rate;
      valid_n  = o_valid;
      update_n = 1'b0;
      if (timeout) begin
         valid_n = 1'b0;
         lock_n  = '0;
      end else if (meas_pulse) begin
         if (!meas_match) begin
            valid_n = 1'b0;
            lock_n  = '0;
         end else if (meas_class == cand) begin
            lock_n = lock_inc;
         end else begin
            cand_n  = meas_class;
            lock_n  = c_ONE;
            valid_n = 1'b0;
         end
      end
      if (lock_entry) begin
         rate_n   = cand_n;
         valid_n  = 1'b1;
         update_n = 1'b1;
      end
   end

endmodule

// File: tb/tb_blink_rate_decoder.sv
// tb/tb_blink_rate_decoder.sv - scoreboard bench for blink_rate_decoder with
// scaled-down half-periods.
module tb_blink_rate_decoder;

   localparam int P100 = 200;
   localparam int P50  = 400;
   localparam int P10  = 1000;
   localparam int P1   = 2000;
   localparam int TO   = 4000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sig = 1'b0;
   logic [1:0]  rate;
   logic        valid;
   logic        update;
   logic [31:0] hp;

   blink_rate_decoder #(
      .c_CNT_100HZ (P100),
      .c_CNT_50HZ  (P50),
      .c_CNT_10HZ  (P10),
      .c_CNT_1HZ   (P1),
      .c_TOL_SHIFT (3),
      .c_LOCK_COUNT(2),
      .c_TIMEOUT   (TO)
   ) dut (
      .i_clock      (clk),
      .i_reset_n    (rst_n),
      .i_signal     (sig),
      .o_rate       (rate),
      .o_valid      (valid),
      .o_update     (update),
      .o_half_period(hp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int          cyc;
      logic        v;
      logic [1:0]  r;
      logic        u;
      logic [31:0] hp;
   } ev_t;

   ev_t q[$];
   int  t_tog = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic tog(input int n);
      repeat (n) @(negedge clk);
      sig   = ~sig;
      t_tog = cyc;
   endtask

   task automatic ex(input int d, input logic v, input logic [1:0] r, input logic u, input int h);
      ev_t e;
      e.cyc = t_tog + d;
      e.v   = v;
      e.r   = r;
      e.u   = u;
      e.hp  = 32'(h);
      q.push_back(e);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"},  32'(valid),  32'd0);
      chk({tag, "_update"}, 32'(update), 32'd0);
      chk({tag, "_rate"},   32'(rate),   32'd0);
      chk({tag, "_hp"},     hp,          32'd0);
   endtask

   logic [35:0] prev = '0;

   always @(negedge clk) begin
      logic [35:0] cur;
      ev_t e;
      cur = {valid, rate, update, hp};
      if (!rst_n) begin
         prev = '0;
      end else if (cur !== prev) begin
         n_vec++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change: cycle %0d v=%0d rate=%0d upd=%0d hp=%0d, want no change",
                     cyc, valid, rate, update, hp);
         end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.v !== valid || e.r !== rate || e.u !== update || e.hp !== hp) begin
               n_bad++;
               $display("FAIL output_event: got cycle %0d v=%0d rate=%0d upd=%0d hp=%0d, want cycle %0d v=%0d rate=%0d upd=%0d hp=%0d",
                        cyc, valid, rate, update, hp, e.cyc, e.v, e.r, e.u, e.hp);
            end
         end
         prev = cur;
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      #1 chk_zero("reset");
      @(negedge clk);
      #2 rst_n = 1'b1;

      // 100 Hz lock: arm, measure, lock
      tog(10);
      tog(P100); ex(3, 1'b0, 2'd0, 1'b0, 200);
      tog(P100); ex(4, 1'b1, 2'd0, 1'b1, 200); ex(5, 1'b1, 2'd0, 1'b0, 200);

      // tolerance edges at 100 Hz
      tog(225); ex(3, 1'b1, 2'd0, 1'b0, 225);
      tog(175); ex(3, 1'b1, 2'd0, 1'b0, 175);
      tog(226); ex(3, 1'b1, 2'd0, 1'b0, 226); ex(4, 1'b0, 2'd0, 1'b0, 226);
      tog(P100); ex(3, 1'b0, 2'd0, 1'b0, 200);
      tog(P100); ex(4, 1'b1, 2'd0, 1'b1, 200); ex(5, 1'b1, 2'd0, 1'b0, 200);

      // rate change to 1 Hz
      tog(P1); ex(3, 1'b1, 2'd0, 1'b0, 2000); ex(4, 1'b0, 2'd0, 1'b0, 2000);
      tog(P1); ex(4, 1'b1, 2'd3, 1'b1, 2000); ex(5, 1'b1, 2'd3, 1'b0, 2000);

      // 50 Hz lock, then a glitch pair and recovery
      tog(P50); ex(3, 1'b1, 2'd3, 1'b0, 400); ex(4, 1'b0, 2'd3, 1'b0, 400);
      tog(P50); ex(4, 1'b1, 2'd1, 1'b1, 400); ex(5, 1'b1, 2'd1, 1'b0, 400);
      tog(100); ex(3, 1'b1, 2'd1, 1'b0, 100); ex(4, 1'b0, 2'd1, 1'b0, 100);
      tog(2);   ex(3, 1'b0, 2'd1, 1'b0, 2);
      tog(298); ex(3, 1'b0, 2'd1, 1'b0, 298);
      tog(P50); ex(3, 1'b0, 2'd1, 1'b0, 400);
      tog(P50); ex(4, 1'b1, 2'd1, 1'b1, 400); ex(5, 1'b1, 2'd1, 1'b0, 400);

      // 10 Hz lock, then silence until timeout
      tog(P10); ex(3, 1'b1, 2'd1, 1'b0, 1000); ex(4, 1'b0, 2'd1, 1'b0, 1000);
      tog(P10); ex(4, 1'b1, 2'd2, 1'b1, 1000); ex(5, 1'b1, 2'd2, 1'b0, 1000);
      ex(TO + 4, 1'b0, 2'd2, 1'b0, 1000);
      tog(TO + 100);
      tog(1010); ex(3, 1'b0, 2'd2, 1'b0, 1010);
      tog(990);  ex(3, 1'b0, 2'd2, 1'b0, 990);
                 ex(4, 1'b1, 2'd2, 1'b1, 990); ex(5, 1'b1, 2'd2, 1'b0, 990);

      // asynchronous reset while locked
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      sig = 1'b0;
      #1 chk_zero("midrun_reset");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      tog(5);
      tog(P50); ex(3, 1'b0, 2'd0, 1'b0, 400);
      tog(P50); ex(4, 1'b1, 2'd1, 1'b1, 400); ex(5, 1'b1, 2'd1, 1'b0, 400);

      repeat (20) @(negedge clk);
      chk("events_pending", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
